// File: rtl/daq_apb_host_sequencer.sv
// APB host sequencer: write command, poll status until done/err, read result, return response.
// Optional poll timeout when DAQ_HOST_POLL_TIMEOUT_EN is defined; otherwise polling is unbounded.
module daq_apb_host_sequencer #(
    parameter int          POLL_LIMIT = 64,
    parameter logic [7:0]  CMD_ADDR   = 8'h00,
    parameter logic [7:0]  STAT_ADDR  = 8'h04,
    parameter logic [7:0]  RES_ADDR   = 8'h08
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [7:0]  PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_SETUP,
        S_WR_ACCESS,
        S_POLL_SETUP,
        S_POLL_ACCESS,
        S_RD_SETUP,
        S_RD_ACCESS,
        S_RESP
    } state_t;

    if (POLL_LIMIT < 1) begin : g_bad_poll_limit
        $error("POLL_LIMIT must be at least 1");
    end

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_cmd;
    logic [31:0] r_rsp_data;
    logic        r_rsp_err;
    logic        w_poll_timeout;

`ifdef DAQ_HOST_POLL_TIMEOUT_EN
    localparam int PCW = $clog2(POLL_LIMIT + 1);
    logic [PCW-1:0] r_poll_cnt;

    // This poll is the POLL_LIMIT-th consecutive not-done one.
    assign w_poll_timeout = (r_poll_cnt == PCW'(POLL_LIMIT - 1));
`else
    assign w_poll_timeout = 1'b0;
`endif

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:        if (cmd_valid) w_next = S_WR_SETUP;
            S_WR_SETUP:    w_next = S_WR_ACCESS;
            S_WR_ACCESS: begin
                if (PREADY) w_next = PSLVERR ? S_RESP : S_POLL_SETUP;
            end
            S_POLL_SETUP:  w_next = S_POLL_ACCESS;
            S_POLL_ACCESS: begin
                if (PREADY) begin
                    if (PSLVERR || PRDATA[1]) w_next = S_RESP;
                    else if (PRDATA[0])       w_next = S_RD_SETUP;
                    else if (w_poll_timeout)  w_next = S_RESP;
                    else                      w_next = S_POLL_SETUP;
                end
            end
            S_RD_SETUP:    w_next = S_RD_ACCESS;
            S_RD_ACCESS:   if (PREADY) w_next = S_RESP;
            S_RESP:        if (rsp_ready) w_next = S_IDLE;
            default:       w_next = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (r_state == S_IDLE);
        rsp_valid = (r_state == S_RESP);
        rsp_err   = (r_state == S_RESP) && r_rsp_err;
        rsp_data  = r_rsp_data;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        PWRITE    = 1'b0;
        PADDR     = 8'h00;
        PWDATA    = 32'h0;
        case (r_state)
            S_WR_SETUP, S_WR_ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = (r_state == S_WR_ACCESS);
                PWRITE  = 1'b1;
                PADDR   = CMD_ADDR;
                PWDATA  = r_cmd;
            end
            S_POLL_SETUP, S_POLL_ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = (r_state == S_POLL_ACCESS);
                PADDR   = STAT_ADDR;
            end
            S_RD_SETUP, S_RD_ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = (r_state == S_RD_ACCESS);
                PADDR   = RES_ADDR;
            end
            default: ;
        endcase
    end

    // Response capture: write errors report zero, read/poll errors report the returned word.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_cmd      <= 32'h0;
            r_rsp_data <= 32'h0;
            r_rsp_err  <= 1'b0;
`ifdef DAQ_HOST_POLL_TIMEOUT_EN
            r_poll_cnt <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_cmd     <= cmd_data;
                        r_rsp_err <= 1'b0;
                    end
                end
                S_WR_ACCESS: begin
                    if (PREADY) begin
                        r_rsp_data <= 32'h0;
                        r_rsp_err  <= PSLVERR;
`ifdef DAQ_HOST_POLL_TIMEOUT_EN
                        r_poll_cnt <= '0;
`endif
                    end
                end
                S_POLL_ACCESS: begin
                    if (PREADY) begin
                        r_rsp_data <= PRDATA;
                        r_rsp_err  <= PSLVERR || PRDATA[1] || (!PRDATA[0] && w_poll_timeout);
`ifdef DAQ_HOST_POLL_TIMEOUT_EN
                        if (!PSLVERR && !PRDATA[1] && !PRDATA[0]) begin
                            r_poll_cnt <= r_poll_cnt + PCW'(1);
                        end
`endif
                    end
                end
                S_RD_ACCESS: begin
                    if (PREADY) begin
                        r_rsp_data <= PRDATA;
                        r_rsp_err  <= PSLVERR;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_daq_apb_host_sequencer.sv
// Directed bench for daq_apb_host_sequencer with a small APB completer model and transfer log.
module tb_daq_apb_host_sequencer;

`ifdef DAQ_HOST_POLL_TIMEOUT_EN
    localparam int PL = 4;
`else
    localparam int PL = 64;
`endif

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        PSEL, PENABLE, PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    daq_apb_host_sequencer #(.POLL_LIMIT(PL)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int errors = 0;
    int checks = 0;

    logic [7:0]  log_addr[$];
    logic        log_we[$];
    logic [31:0] log_wdata[$];
    logic [31:0] stat_q[$];
    logic [31:0] stat_dflt = 32'h1;
    logic [31:0] res_val   = 32'h0;

    always @(posedge PCLK) begin
        if (!PRESET && PSEL && PENABLE && PREADY) begin
            log_addr.push_back(PADDR);
            log_we.push_back(PWRITE);
            log_wdata.push_back(PWDATA);
            if (PADDR == 8'h04 && !PWRITE && stat_q.size() > 0) void'(stat_q.pop_front());
        end
    end

    always @(negedge PCLK) begin
        if (PADDR == 8'h08) PRDATA = res_val;
        else PRDATA = (stat_q.size() > 0) ? stat_q[0] : stat_dflt;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic handshake(input logic [31:0] d, input bit keep);
        @(negedge PCLK);
        cmd_valid = 1'b1;
        cmd_data  = d;
        check("cmd_ready_before_hs", {31'b0, cmd_ready}, 32'd1);
        @(posedge PCLK);
        #1;
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(negedge PCLK);
            lat++;
        end while (!rsp_valid && lat < 300);
    endtask

    task automatic accept_rsp();
        @(negedge PCLK);
        rsp_ready = 1'b1;
        @(posedge PCLK);
        #1;
        rsp_ready = 1'b0;
        @(negedge PCLK);
        check("rsp_valid_after_accept", {31'b0, rsp_valid}, 32'd0);
        check("cmd_ready_after_accept", {31'b0, cmd_ready}, 32'd1);
    endtask

    function automatic int count_reads(input logic [7:0] a);
        int n = 0;
        foreach (log_addr[i]) if (log_addr[i] == a && !log_we[i]) n++;
        return n;
    endfunction

    function automatic int count_writes();
        int n = 0;
        foreach (log_we[i]) if (log_we[i]) n++;
        return n;
    endfunction

    function automatic void clear_log();
        log_addr.delete();
        log_we.delete();
        log_wdata.delete();
    endfunction

    initial begin
        int lat;
        int bad;
        int seen;
        PRESET = 1'b1; cmd_valid = 1'b0; cmd_data = 32'h0; rsp_ready = 1'b0;
        PREADY = 1'b1; PSLVERR = 1'b0;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        check("rst_psel",      {31'b0, PSEL},      32'd0);
        check("rst_penable",   {31'b0, PENABLE},   32'd0);
        check("rst_pwrite",    {31'b0, PWRITE},    32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_err",   {31'b0, rsp_err},   32'd0);
        check("rst_paddr",     {24'b0, PADDR},     32'd0);
        check("rst_pwdata",    PWDATA,             32'd0);
        check("rst_rsp_data",  rsp_data,           32'd0);
        PRESET = 1'b0;

        // Basic command: done on first poll.
        clear_log();
        stat_q = '{32'h1};
        res_val = 32'hCAFE_0042;
        handshake(32'h0000_0103, 1'b0);
        wait_rsp(lat);
        check("t1_latency",   lat,                7);
        check("t1_rsp_data",  rsp_data,           32'hCAFE_0042);
        check("t1_rsp_err",   {31'b0, rsp_err},   32'd0);
        check("t1_xfers",     log_addr.size(),    3);
        check("t1_wr_addr",   {24'b0, log_addr[0]}, 32'h00);
        check("t1_wr_we",     {31'b0, log_we[0]},   32'd1);
        check("t1_wr_data",   log_wdata[0],         32'h0000_0103);
        check("t1_poll_addr", {24'b0, log_addr[1]}, 32'h04);
        check("t1_res_addr",  {24'b0, log_addr[2]}, 32'h08);
        repeat (2) @(negedge PCLK);
        check("t1_hold_valid", {31'b0, rsp_valid}, 32'd1);
        check("t1_hold_data",  rsp_data,           32'hCAFE_0042);
        accept_rsp();

        // Three busy polls then done; cmd_valid held high throughout must not queue.
        clear_log();
        stat_q = '{32'h4, 32'h4, 32'h4, 32'h1};
        res_val = 32'h1234_5678;
        handshake(32'h0000_0200, 1'b1);
        wait_rsp(lat);
        cmd_valid = 1'b0;
        check("t2_latency",    lat,               13);
        check("t2_polls",      count_reads(8'h04), 4);
        check("t2_res_reads",  count_reads(8'h08), 1);
        check("t2_writes",     count_writes(),     1);
        check("t2_rsp_data",   rsp_data,           32'h1234_5678);
        accept_rsp();

        // err_sticky on first poll: no result read.
        clear_log();
        stat_q = '{32'h2};
        handshake(32'h0000_0300, 1'b0);
        wait_rsp(lat);
        check("t3_latency",   lat,                5);
        check("t3_rsp_err",   {31'b0, rsp_err},   32'd1);
        check("t3_rsp_data",  rsp_data,           32'h0000_0002);
        check("t3_res_reads", count_reads(8'h08), 0);
        accept_rsp();

        // Write stalled 3 cycles, completes with PSLVERR.
        clear_log();
        PREADY = 1'b0;
        handshake(32'hA5A5_0001, 1'b0);
        bad = 0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge PCLK);
            if (i == 5) begin
                PREADY = 1'b1;
                PSLVERR = 1'b1;
            end
            if (PADDR !== 8'h00 || PWDATA !== 32'hA5A5_0001 || PWRITE !== 1'b1 ||
                PSEL !== 1'b1 || PENABLE !== (i > 1)) bad++;
        end
        check("t4_stable_cycles_bad", bad, 0);
        @(negedge PCLK);
        PSLVERR = 1'b0;
        check("t4_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        check("t4_rsp_err",   {31'b0, rsp_err},   32'd1);
        check("t4_rsp_data",  rsp_data,           32'h0);
        check("t4_polls",     count_reads(8'h04), 0);
        accept_rsp();

`ifdef DAQ_HOST_POLL_TIMEOUT_EN
        // Status stuck busy: times out after POLL_LIMIT polls.
        clear_log();
        stat_q.delete();
        stat_dflt = 32'h4;
        handshake(32'h0000_0400, 1'b0);
        wait_rsp(lat);
        check("t6_latency",   lat,                11);
        check("t6_polls",     count_reads(8'h04), 4);
        check("t6_rsp_err",   {31'b0, rsp_err},   32'd1);
        check("t6_rsp_data",  rsp_data,           32'h0000_0004);
        accept_rsp();
`endif

        // Reset during a poll access aborts without a response.
        stat_q.delete();
        stat_dflt = 32'h4;
        handshake(32'h0000_0500, 1'b0);
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(negedge PCLK);
            if (PSEL && PENABLE && PADDR == 8'h04) seen = 1;
        end
        check("t5_reached_poll_access", seen, 1);
        PRESET = 1'b1;
        rsp_ready = 1'b0;
        @(posedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b0;
        check("t5_psel_after_rst",    {31'b0, PSEL},      32'd0);
        check("t5_penable_after_rst", {31'b0, PENABLE},   32'd0);
        check("t5_cmd_ready",         {31'b0, cmd_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge PCLK);
            if (rsp_valid || PSEL) seen++;
        end
        check("t5_no_rsp_or_xfer", seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
